// File: rtl/xor_stream_checksum_if.sv
// Valid/ready bundle for the XOR stream checksum: an upstream word stream
// coming in and a downstream checksum/length result going out.
interface xor_stream_checksum_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) ();

   logic             up_vld;
   logic             up_rdy;
   logic [WIDTH-1:0] up_data;
   logic             up_last;
   logic             down_vld;
   logic             down_rdy;
   logic [WIDTH-1:0] down_data;
   logic [LEN_W-1:0] down_len;

   // Environment side: produces words, consumes results
   modport master (
      output up_vld,
      input  up_rdy,
      output up_data,
      output up_last,
      input  down_vld,
      output down_rdy,
      input  down_data,
      input  down_len
   );

   // Checksum block side: consumes words, produces results
   modport slave (
      input  up_vld,
      output up_rdy,
      input  up_data,
      input  up_last,
      output down_vld,
      input  down_rdy,
      output down_data,
      output down_len
   );

endinterface

// File: rtl/xor_stream_checksum.sv
// Packet XOR/XNOR checksum. Words of a packet are folded into a running XOR
// accumulator while a beat counter tracks packet length. When the last beat
// is accepted, the checksum and length land in a single holding register that
// drains through a valid/ready handshake. A new packet can accumulate while
// the previous result drains, and a consume plus a new last beat on the same
// edge reloads the register without a bubble.
module xor_stream_checksum #(
   parameter int WIDTH  = 8,
   parameter int LEN_W  = 8,
   parameter int INVERT = 0
) (
   input logic                  clk,
   input logic                  rst,
   xor_stream_checksum_if.slave bus
);

   localparam logic [WIDTH-1:0] INV_MASK = (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   logic [WIDTH-1:0] acc;
   logic [LEN_W-1:0] cnt;
   logic             res_vld;
   logic [WIDTH-1:0] res_data;
   logic [LEN_W-1:0] res_len;

   logic             rdy;
   logic             accept;
   logic             consume;
   logic [WIDTH-1:0] acc_sum;
   logic [LEN_W-1:0] cnt_inc;

   logic [WIDTH-1:0] acc_nxt;
   logic [LEN_W-1:0] cnt_nxt;
   logic             res_vld_nxt;
   logic [WIDTH-1:0] res_data_nxt;
   logic [LEN_W-1:0] res_len_nxt;

   // The holding register frees up on the same edge it is consumed, so ready
   // only depends on the output side and never on the upstream inputs.
   assign rdy     = !res_vld || bus.down_rdy;
   assign accept  = bus.up_vld && rdy;
   assign consume = res_vld && bus.down_rdy;
   assign acc_sum = acc ^ bus.up_data;
   assign cnt_inc = cnt + LEN_W'(1);

   // Next-state for accumulator, counter and result register
   always_comb begin
      acc_nxt      = acc;
      cnt_nxt      = cnt;
      res_vld_nxt  = res_vld;
      res_data_nxt = res_data;
      res_len_nxt  = res_len;
      if (consume) begin
         res_vld_nxt = 1'b0;
      end
      if (accept) begin
         if (bus.up_last) begin
            res_data_nxt = acc_sum ^ INV_MASK;
            res_len_nxt  = cnt_inc;
            res_vld_nxt  = 1'b1;
            acc_nxt      = '0;
            cnt_nxt      = '0;
         end else begin
            acc_nxt = acc_sum;
            cnt_nxt = cnt_inc;
         end
      end
   end

   // State registers; reset wins over any handshake on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         res_vld  <= 1'b0;
         res_data <= '0;
         res_len  <= '0;
      end else begin
         acc      <= acc_nxt;
         cnt      <= cnt_nxt;
         res_vld  <= res_vld_nxt;
         res_data <= res_data_nxt;
         res_len  <= res_len_nxt;
      end
   end

   assign bus.up_rdy    = rdy;
   assign bus.down_vld  = res_vld;
   assign bus.down_data = res_data;
   assign bus.down_len  = res_len;

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Directed bench for xor_stream_checksum. Three instances cover the plain
// XOR build, the XNOR build and a narrow 2-bit length counter that wraps.
module tb_xor_stream_checksum;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   xor_stream_checksum_if #(.WIDTH(8), .LEN_W(8)) if0 ();
   xor_stream_checksum_if #(.WIDTH(8), .LEN_W(8)) if1 ();
   xor_stream_checksum_if #(.WIDTH(8), .LEN_W(2)) if2 ();

   xor_stream_checksum #(.WIDTH(8), .LEN_W(8), .INVERT(0)) u_xor (
      .clk (clk),
      .rst (rst),
      .bus (if0.slave)
   );

   xor_stream_checksum #(.WIDTH(8), .LEN_W(8), .INVERT(1)) u_xnor (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   xor_stream_checksum #(.WIDTH(8), .LEN_W(2), .INVERT(0)) u_wrap (
      .clk (clk),
      .rst (rst),
      .bus (if2.slave)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one instance with the given beat, idle the others, then advance
   // one rising edge and settle 1 unit past it before returning.
   task automatic applyStimulus(input int sel, input logic vld, input logic [7:0] data,
                                input logic last, input logic drdy);
      if0.up_vld = 1'b0; if0.up_data = 8'h00; if0.up_last = 1'b0; if0.down_rdy = 1'b1;
      if1.up_vld = 1'b0; if1.up_data = 8'h00; if1.up_last = 1'b0; if1.down_rdy = 1'b1;
      if2.up_vld = 1'b0; if2.up_data = 8'h00; if2.up_last = 1'b0; if2.down_rdy = 1'b1;
      case (sel)
         0: begin if0.up_vld = vld; if0.up_data = data; if0.up_last = last; if0.down_rdy = drdy; end
         1: begin if1.up_vld = vld; if1.up_data = data; if1.up_last = last; if1.down_rdy = drdy; end
         default: begin if2.up_vld = vld; if2.up_data = data; if2.up_last = last; if2.down_rdy = drdy; end
      endcase
      @(posedge clk);
      #1;
   endtask

   // Compare one instance's outputs against hand-computed values
   task automatic checkOutput(input string tag, input int sel, input logic exp_vld,
                              input logic [7:0] exp_data, input logic [7:0] exp_len,
                              input logic exp_rdy);
      logic       o_vld;
      logic [7:0] o_data;
      logic [7:0] o_len;
      logic       o_rdy;
      case (sel)
         0: begin o_vld = if0.down_vld; o_data = if0.down_data; o_len = if0.down_len; o_rdy = if0.up_rdy; end
         1: begin o_vld = if1.down_vld; o_data = if1.down_data; o_len = if1.down_len; o_rdy = if1.up_rdy; end
         default: begin o_vld = if2.down_vld; o_data = if2.down_data; o_len = {6'd0, if2.down_len}; o_rdy = if2.up_rdy; end
      endcase
      tests_run++;
      assert (o_vld === exp_vld) else begin
         tests_failed++;
         $error("[TB] FAIL %s down_vld: observed %b expected %b", tag, o_vld, exp_vld);
      end
      tests_run++;
      assert (o_data === exp_data) else begin
         tests_failed++;
         $error("[TB] FAIL %s down_data: observed %h expected %h", tag, o_data, exp_data);
      end
      tests_run++;
      assert (o_len === exp_len) else begin
         tests_failed++;
         $error("[TB] FAIL %s down_len: observed %0d expected %0d", tag, o_len, exp_len);
      end
      tests_run++;
      assert (o_rdy === exp_rdy) else begin
         tests_failed++;
         $error("[TB] FAIL %s up_rdy: observed %b expected %b", tag, o_rdy, exp_rdy);
      end
   endtask

   // Directed sequence
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;

      // Reset state on all three instances
      applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("reset_xor",  0, 1'b0, 8'h00, 8'd0, 1'b1);
      checkOutput("reset_xnor", 1, 1'b0, 8'h00, 8'd0, 1'b1);
      checkOutput("reset_wrap", 2, 1'b0, 8'h00, 8'd0, 1'b1);
      rst = 1'b0;

      // Three-beat packet 0F ^ F0 ^ 3C = C3, length 3
      applyStimulus(0, 1'b1, 8'h0F, 1'b0, 1'b1);
      checkOutput("pkt3_beat0", 0, 1'b0, 8'h00, 8'd0, 1'b1);
      applyStimulus(0, 1'b1, 8'hF0, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 8'h3C, 1'b1, 1'b1);
      checkOutput("pkt3_result", 0, 1'b1, 8'hC3, 8'd3, 1'b1);
      applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("pkt3_drained", 0, 1'b0, 8'hC3, 8'd3, 1'b1);

      // Back-to-back single-beat packets, no bubble
      applyStimulus(0, 1'b1, 8'hA5, 1'b1, 1'b1);
      checkOutput("b2b_first", 0, 1'b1, 8'hA5, 8'd1, 1'b1);
      applyStimulus(0, 1'b1, 8'h5A, 1'b1, 1'b1);
      checkOutput("b2b_second", 0, 1'b1, 8'h5A, 8'd1, 1'b1);
      applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("b2b_drained", 0, 1'b0, 8'h5A, 8'd1, 1'b1);

      // Backpressure: result 11 held, upstream stalled, then release
      applyStimulus(0, 1'b1, 8'h11, 1'b1, 1'b0);
      checkOutput("bp_loaded", 0, 1'b1, 8'h11, 8'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1'b1, 8'h22, 1'b1, 1'b0);
         checkOutput($sformatf("bp_hold%0d", i), 0, 1'b1, 8'h11, 8'd1, 1'b0);
      end
      applyStimulus(0, 1'b1, 8'h22, 1'b1, 1'b1);
      checkOutput("bp_release", 0, 1'b1, 8'h22, 8'd1, 1'b1);
      applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("bp_drained", 0, 1'b0, 8'h22, 8'd1, 1'b1);

      // XNOR build: 00,00 -> FF len 2; FF -> 00 len 1
      applyStimulus(1, 1'b1, 8'h00, 1'b0, 1'b1);
      applyStimulus(1, 1'b1, 8'h00, 1'b1, 1'b1);
      checkOutput("xnor_zeros", 1, 1'b1, 8'hFF, 8'd2, 1'b1);
      applyStimulus(1, 1'b1, 8'hFF, 1'b1, 1'b1);
      checkOutput("xnor_ones", 1, 1'b1, 8'h00, 8'd1, 1'b1);
      applyStimulus(1, 1'b0, 8'h00, 1'b0, 1'b1);

      // 2-bit length counter: five beats of 01 -> checksum 01, length 5 mod 4 = 1
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2, 1'b1, 8'h01, 1'b0, 1'b1);
      end
      applyStimulus(2, 1'b1, 8'h01, 1'b1, 1'b1);
      checkOutput("wrap_len", 2, 1'b1, 8'h01, 8'd1, 1'b1);
      applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b1);

      // Reset mid-packet, with a beat offered during reset that must be dropped
      applyStimulus(0, 1'b1, 8'h55, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 8'hAA, 1'b0, 1'b1);
      rst = 1'b1;
      applyStimulus(0, 1'b1, 8'hFF, 1'b0, 1'b1);
      checkOutput("midrst_state", 0, 1'b0, 8'h00, 8'd0, 1'b1);
      rst = 1'b0;
      applyStimulus(0, 1'b1, 8'h0F, 1'b1, 1'b1);
      checkOutput("midrst_result", 0, 1'b1, 8'h0F, 8'd1, 1'b1);
      applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
